td4w_core: RTL and testbench
============================

# td4w_core

Parametrised successor to the 4-bit TD4 core. It keeps the TD4 instruction set and A/B/carry programming model, and generalises the data, immediate and address width to DW bits. It adds a stallable instruction-fetch handshake, a synchronised GPI, a GPO write strobe, and ADD A,B and HALT opcodes. It sits between an external program memory (ROM/RAM model or bus bridge) and board-level GPIO, replacing the combinational `op` = ram[ip] hookup.

## Interface
- DW, 4, data / immediate / address width; legal 4..8; program depth 2^DW words
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req  out  1  fetch request; high only in FETCH
- imem_addr  out  DW  fetch address (= ip)
- imem_rdata  in  4+DW  instruction word: [DW+3:DW] opcode, [DW-1:0] Im
- imem_valid  in  1  rdata valid; sampled only while imem_req=1
- gpi  in  DW  asynchronous general input
- gpo  out  DW  general output register
- gpo_stb  out  1  one-cycle pulse after each OUT
- ip  out  DW  instruction pointer
- halted  out  1  core stopped by HALT

## Operation
- States: IDLE (after reset) -> FETCH -> EXEC -> FETCH ...; EXEC of HALT -> HALT (terminal until reset).
- IDLE: leaves unconditionally on the first clk edge with rst_n=1.
- FETCH: imem_req=1, imem_addr=ip. On an edge with imem_valid=1, latch imem_rdata into IR and go to EXEC. Otherwise stay, with no state change (wait states unlimited).
- EXEC executes IR in one edge. Results:
  - 0000 ADD A,Im: {C,A} = A+Im
  - 0101 ADD B,Im: {C,B} = B+Im
  - 1101 ADD A,B: {C,A} = A+B
  - 0011 MOV A,Im; 0111 MOV B,Im; 0001 MOV A,B; 0100 MOV B,A
  - 0010 IN A: A = gpi_s; 0110 IN B: B = gpi_s (Im ignored)
  - 1001 OUT B: gpo = B; 1011 OUT Im: gpo = Im
  - 1111 JMP Im: ip = Im
  - 1110 JNC Im: ip = Im if C==0 (C from previous instruction), else ip+1
  - 1100 HALT: ip unchanged, go to HALT
  - 1000, 1010: NOP
- Carry C: the ADD forms load the carry-out; every other executed instruction clears C, including a taken or not-taken JNC, NOP and OUT. HALT leaves C.
- Arithmetic is modulo 2^DW; ip+1 wraps 2^DW-1 -> 0.
- gpi_s: a two-flop synchroniser on gpi, clocked every cycle in all states.
- HALT state: imem_req=0, halted=1, all registers frozen. Only rst_n exits.
- imem_valid outside FETCH is ignored.

## Timing
- Reset (async, immediate): A=B=C=0, IR=0, ip=0, gpo=0, gpo_stb=0, halted=0, gpi_s=0, state IDLE, imem_req=0.
- First imem_req=1 one cycle after the first edge with rst_n=1, with imem_addr=0.
- Zero-wait memory (imem_valid=1 in the first FETCH cycle): 2 cycles per instruction. Each wait cycle adds 1.
- Register, flag, ip and gpo updates become visible the cycle after the EXEC edge.
- gpo_stb is high for exactly the cycle after an OUT's EXEC edge. Back-to-back OUTs give separate pulses 2 cycles apart.
- A gpi change is visible to IN when it precedes the EXEC edge by at least 2 edges.
- rst_n asserted mid-FETCH (wait state) or mid-EXEC: the operation is abandoned, with no partial update. After deassertion the core refetches from 0.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with imem_valid=1. All outputs must stay 0 and imem_req=0. After release, imem_req rises one cycle later with imem_addr=0.
- Carry/JNC, DW=4: MOV A,0xE; ADD A,1 -> A=0xF, C=0; ADD A,1 -> A=0x0, C=1; JNC 0 not taken (ip=4, C cleared); OUT Im 0x8 -> gpo=4'b1000 and gpo_stb pulses once; JNC 0 then taken -> ip=0.
- Wait states: delay imem_valid by 3 cycles on every fetch of a MOV/ADD program. Each instruction must take 5 cycles with results identical to the zero-wait run. Toggling imem_valid in EXEC has no effect.
- DW=8: MOV B,0xC8; ADD B,0x40 -> B=0x08, C=1; ADD A,B with A=0xFF -> A=0x07, C=1; OUT B -> gpo=0x08 with a single gpo_stb pulse. Fetching past 0xFF wraps ip to 0x00.
- IN/HALT: set gpi=0x5 at least 2 edges before IN A -> A=0x5; OUT B with B set from MOV B,A -> gpo=0x5. HALT at address 6 -> halted=1, imem_req=0, ip=6, gpo unchanged for 100 cycles.
- Async reset in a wait state and in EXEC of ADD: registers clear immediately without clk, the pending add is not applied, and the next fetch is at 0.

Source files
------------

// File: rtl/td4w_imem_if.sv
// Instruction-fetch handshake between td4w_core and program memory.
//   req   : fetch request, high only while the core waits for an instruction
//   addr  : fetch address (current instruction pointer)
//   rdata : instruction word, [DW+3:DW] opcode, [DW-1:0] immediate
//   valid : rdata valid; only looked at while req is high
interface td4w_imem_if #(
    parameter int unsigned DW = 4
);
    logic          req;
    logic [DW-1:0] addr;
    logic [DW+3:0] rdata;
    logic          valid;

    modport master (output req, addr, input rdata, valid);
    modport slave  (input req, addr, output rdata, valid);
endinterface

// File: rtl/td4w_core.sv
// TD4-compatible core with DW-bit data path, stallable fetch, synchronised
// GPI, GPO write strobe, ADD A,B and HALT.
//   clk, rst_n : clock, asynchronous active-low reset
//   imem       : fetch handshake (master side)
//   gpi        : asynchronous general input (two-flop synchronised)
//   gpo        : general output register
//   gpo_stb    : one-cycle pulse after each OUT
//   ip         : instruction pointer
//   halted     : high once HALT has executed, until reset
module td4w_core #(
    parameter int unsigned DW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    td4w_imem_if.master     imem,
    input  logic [DW-1:0]   gpi,
    output logic [DW-1:0]   gpo,
    output logic            gpo_stb,
    output logic [DW-1:0]   ip,
    output logic            halted
);
    localparam int unsigned IW = DW + 4;

    localparam logic [3:0] OP_ADD_AI = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_BI = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_HALT   = 4'b1100;
    localparam logic [3:0] OP_ADD_AB = 4'b1101;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, ip_q, ip_d, gpo_q, gpo_d;
    logic          c_q, c_d, stb_q, stb_d, halted_q, halted_d, req_q, req_d;
    logic [DW-1:0] gpi_m, gpi_s;
    logic [3:0]    opc;
    logic [DW-1:0] im;
    logic [DW:0]   sum;

    assign opc = ir_q[IW-1:DW];
    assign im  = ir_q[DW-1:0];

    // Next-state, datapath and output-register decode
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        ip_d    = ip_q;
        gpo_d   = gpo_q;
        stb_d   = 1'b0;
        sum     = '0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem.valid) begin
                    ir_d    = imem.rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Non-ADD instructions clear carry; HALT overrides below
                state_d = S_FETCH;
                ip_d    = ip_q + DW'(1);
                c_d     = 1'b0;
                case (opc)
                    OP_ADD_AI: begin
                        sum = {1'b0, a_q} + {1'b0, im};
                        {c_d, a_d} = sum;
                    end
                    OP_ADD_BI: begin
                        sum = {1'b0, b_q} + {1'b0, im};
                        {c_d, b_d} = sum;
                    end
                    OP_ADD_AB: begin
                        sum = {1'b0, a_q} + {1'b0, b_q};
                        {c_d, a_d} = sum;
                    end
                    OP_MOV_AI: a_d = im;
                    OP_MOV_BI: b_d = im;
                    OP_MOV_AB: a_d = b_q;
                    OP_MOV_BA: b_d = a_q;
                    OP_IN_A:   a_d = gpi_s;
                    OP_IN_B:   b_d = gpi_s;
                    OP_OUT_B: begin
                        gpo_d = b_q;
                        stb_d = 1'b1;
                    end
                    OP_OUT_I: begin
                        gpo_d = im;
                        stb_d = 1'b1;
                    end
                    OP_JMP:    ip_d = im;
                    OP_JNC:    if (!c_q) ip_d = im;
                    OP_HALT: begin
                        state_d = S_HALT;
                        ip_d    = ip_q;
                        c_d     = c_q;
                    end
                    default: ;
                endcase
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        req_d    = (state_d == S_FETCH);
        halted_d = (state_d == S_HALT);
    end

    // State and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            ip_q     <= '0;
            gpo_q    <= '0;
            stb_q    <= 1'b0;
            halted_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            ip_q     <= ip_d;
            gpo_q    <= gpo_d;
            stb_q    <= stb_d;
            halted_q <= halted_d;
            req_q    <= req_d;
        end
    end

    // GPI synchroniser, runs in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpi_m <= '0;
            gpi_s <= '0;
        end else begin
            gpi_m <= gpi;
            gpi_s <= gpi_m;
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = ip_q;
    assign gpo       = gpo_q;
    assign gpo_stb   = stb_q;
    assign ip        = ip_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_td4w_core.sv
// Testbench for td4w_core: DW=4 and DW=8 instances, table-driven programs,
// hand-written reset/halt/IN sequences and random programs checked against
// an instruction-level model.
module tb_td4w_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4_n, rst8_n;
    logic [3:0] gpi4, gpo4, ip4;
    logic [7:0] gpi8, gpo8, ip8;
    logic       stb4, halted4, stb8, halted8;

    td4w_imem_if #(.DW(4)) bus4 ();
    td4w_imem_if #(.DW(8)) bus8 ();

    td4w_core #(.DW(4)) u4 (.clk(clk), .rst_n(rst4_n), .imem(bus4), .gpi(gpi4),
                            .gpo(gpo4), .gpo_stb(stb4), .ip(ip4), .halted(halted4));
    td4w_core #(.DW(8)) u8 (.clk(clk), .rst_n(rst8_n), .imem(bus8), .gpi(gpi8),
                            .gpo(gpo8), .gpo_stb(stb8), .ip(ip8), .halted(halted8));

    typedef struct {
        logic [7:0] addr;
        logic [3:0] op;
        logic [7:0] im;
        logic [7:0] exp_ip;
        logic [7:0] exp_gpo;
        int         exp_stb;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0]  mem4 [16];
    logic [11:0] mem8 [256];
    int wait4 = 0, tgt4 = 0, cnt4 = 0, vmode4 = 0, vmode8 = 0;
    bit wrand4 = 0;
    int cyc = 0, scnt4 = 0, scnt8 = 0;
    logic acc4, acc8;
    int n_chk = 0, n_fail = 0;
    int m_a, m_b, m_c, m_ip, m_gpo;

    // Memory models: dut4 with programmable wait states, dut8 zero-wait
    always @(negedge clk) begin
        if (bus4.req === 1'b1) begin
            if (cnt4 == 0) tgt4 = wrand4 ? int'($urandom_range(0, 3)) : wait4;
            bus4.rdata = mem4[bus4.addr];
            bus4.valid = (cnt4 == tgt4);
            cnt4++;
        end else begin
            cnt4 = 0;
            bus4.rdata = 8'($urandom);
            bus4.valid = (vmode4 == 2) ? 1'b1 : (vmode4 == 1) ? 1'($urandom) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus8.req === 1'b1) begin
            bus8.rdata = mem8[bus8.addr];
            bus8.valid = 1'b1;
        end else begin
            bus8.rdata = 12'($urandom);
            bus8.valid = (vmode8 == 1) ? 1'($urandom) : 1'b0;
        end
    end

    // acc = fetch accepted last edge, i.e. the core is in its execute cycle
    always @(posedge clk or negedge rst4_n)
        if (!rst4_n) acc4 <= 1'b0; else acc4 <= bus4.req & bus4.valid;
    always @(posedge clk or negedge rst8_n)
        if (!rst8_n) acc8 <= 1'b0; else acc8 <= bus8.req & bus8.valid;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (stb4 === 1'b1) scnt4 <= scnt4 + 1;
        if (stb8 === 1'b1) scnt8 <= scnt8 + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] g_ip(input int w);
        return (w == 4) ? {4'h0, ip4} : ip8;
    endfunction
    function automatic logic [7:0] g_gpo(input int w);
        return (w == 4) ? {4'h0, gpo4} : gpo8;
    endfunction
    function automatic int g_scnt(input int w);
        return (w == 4) ? scnt4 : scnt8;
    endfunction

    // Wait for the next execute edge; returns just after it with results visible
    task automatic wait_done(input int w);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((w == 4) ? acc4 : acc8) !== 1'b1) && n < 60);
        if (n >= 60) begin
            n_chk++;
            n_fail++;
            $display("FAIL exec timeout dut%0d", w);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int w);
        @(negedge clk);
        if (w == 4) rst4_n = 1'b0; else rst8_n = 1'b0;
        repeat (2) @(negedge clk);
        if (w == 4) rst4_n = 1'b1; else rst8_n = 1'b1;
    endtask

    task automatic fill_nop(input int w);
        if (w == 4) for (int i = 0; i < 16; i++) mem4[i] = 8'h80;
        else for (int i = 0; i < 256; i++) mem8[i] = 12'h800;
    endtask

    function automatic vec_t mk(input logic [7:0] addr, input logic [3:0] op, input logic [7:0] im,
                                input logic [7:0] eip, input logic [7:0] egpo, input int estb);
        vec_t v;
        v.addr = addr; v.op = op; v.im = im;
        v.exp_ip = eip; v.exp_gpo = egpo; v.exp_stb = estb;
        return v;
    endfunction

    task automatic run_table(input int w, input int waitn);
        int t0, sc;
        fill_nop(w);
        foreach (tbl[i]) begin
            if (w == 4) mem4[tbl[i].addr[3:0]] = {tbl[i].op, tbl[i].im[3:0]};
            else mem8[tbl[i].addr] = {tbl[i].op, tbl[i].im};
        end
        if (w == 4) begin wait4 = waitn; wrand4 = 0; vmode4 = 1; end
        else vmode8 = 1;
        do_reset(w);
        t0 = cyc;
        for (int i = 0; i < tbl.size(); i++) begin
            sc = g_scnt(w);
            wait_done(w);
            chk($sformatf("dw%0d wait%0d step%0d ip", w, waitn, i), g_ip(w), tbl[i].exp_ip);
            chk($sformatf("dw%0d wait%0d step%0d gpo", w, waitn, i), g_gpo(w), tbl[i].exp_gpo);
            chk($sformatf("dw%0d wait%0d step%0d stb", w, waitn, i), g_scnt(w) - sc, tbl[i].exp_stb);
            if (i > 0)
                chk($sformatf("dw%0d wait%0d step%0d cycles", w, waitn, i), cyc - t0, 2 + waitn);
            t0 = cyc;
        end
    endtask

    // Instruction-level model of the DW=4 core
    task automatic model_step(output int stb);
        logic [7:0] w;
        int op, im, nip, s;
        w   = mem4[m_ip];
        op  = int'(w[7:4]);
        im  = int'(w[3:0]);
        nip = (m_ip + 1) % 16;
        stb = 0;
        case (op)
            0:  begin s = m_a + im;  m_a = s % 16; m_c = s / 16; end
            5:  begin s = m_b + im;  m_b = s % 16; m_c = s / 16; end
            13: begin s = m_a + m_b; m_a = s % 16; m_c = s / 16; end
            3:  m_a = im;
            7:  m_b = im;
            1:  m_a = m_b;
            4:  m_b = m_a;
            2:  m_a = int'(gpi4);
            6:  m_b = int'(gpi4);
            9:  begin m_gpo = m_b; stb = 1; end
            11: begin m_gpo = im;  stb = 1; end
            15: nip = im;
            14: if (m_c == 0) nip = im;
            default: ;
        endcase
        if (!(op == 0 || op == 5 || op == 13)) m_c = 0;
        m_ip = nip;
    endtask

    initial begin
        int sc, stbm, n;
        rst4_n = 1'b0; rst8_n = 1'b0;
        gpi4 = '0; gpi8 = '0;
        vmode4 = 2;
        fill_nop(4);
        fill_nop(8);

        // Reset held with imem_valid=1
        repeat (3) begin
            @(negedge clk);
            chk("reset req", bus4.req, 0);
            chk("reset gpo", gpo4, 0);
            chk("reset stb", stb4, 0);
            chk("reset ip", ip4, 0);
            chk("reset halted", halted4, 0);
        end
        rst4_n = 1'b1;
        #1 chk("req before first edge", bus4.req, 0);
        @(posedge clk);
        #1;
        chk("first req", bus4.req, 1);
        chk("first addr", bus4.addr, 0);

        // Carry / JNC / OUT program, zero-wait then 3 wait states
        tbl.delete();
        tbl.push_back(mk(8'h0, 4'h3, 8'hE, 8'h1, 8'h0, 0));
        tbl.push_back(mk(8'h1, 4'h0, 8'h1, 8'h2, 8'h0, 0));
        tbl.push_back(mk(8'h2, 4'h0, 8'h1, 8'h3, 8'h0, 0));
        tbl.push_back(mk(8'h3, 4'hE, 8'h0, 8'h4, 8'h0, 0));
        tbl.push_back(mk(8'h4, 4'hB, 8'h8, 8'h5, 8'h8, 1));
        tbl.push_back(mk(8'h5, 4'hE, 8'h9, 8'h9, 8'h8, 0));
        tbl.push_back(mk(8'h9, 4'h5, 8'hF, 8'hA, 8'h8, 0));
        tbl.push_back(mk(8'hA, 4'hD, 8'h0, 8'hB, 8'h8, 0));
        tbl.push_back(mk(8'hB, 4'hD, 8'h0, 8'hC, 8'h8, 0));
        tbl.push_back(mk(8'hC, 4'hE, 8'h0, 8'hD, 8'h8, 0));
        tbl.push_back(mk(8'hD, 4'h4, 8'h0, 8'hE, 8'h8, 0));
        tbl.push_back(mk(8'hE, 4'h9, 8'h0, 8'hF, 8'hE, 1));
        tbl.push_back(mk(8'hF, 4'hB, 8'h3, 8'h0, 8'h3, 1));
        run_table(4, 0);
        run_table(4, 3);

        // DW=8 arithmetic and ip wrap
        tbl.delete();
        tbl.push_back(mk(8'h00, 4'h7, 8'hC8, 8'h01, 8'h00, 0));
        tbl.push_back(mk(8'h01, 4'h5, 8'h40, 8'h02, 8'h00, 0));
        tbl.push_back(mk(8'h02, 4'hE, 8'h00, 8'h03, 8'h00, 0));
        tbl.push_back(mk(8'h03, 4'h3, 8'hFF, 8'h04, 8'h00, 0));
        tbl.push_back(mk(8'h04, 4'hD, 8'h00, 8'h05, 8'h00, 0));
        tbl.push_back(mk(8'h05, 4'hE, 8'h00, 8'h06, 8'h00, 0));
        tbl.push_back(mk(8'h06, 4'h9, 8'h00, 8'h07, 8'h08, 1));
        tbl.push_back(mk(8'h07, 4'h4, 8'h00, 8'h08, 8'h08, 0));
        tbl.push_back(mk(8'h08, 4'h9, 8'h00, 8'h09, 8'h07, 1));
        tbl.push_back(mk(8'h09, 4'hF, 8'hFE, 8'hFE, 8'h07, 0));
        tbl.push_back(mk(8'hFE, 4'h8, 8'h00, 8'hFF, 8'h07, 0));
        tbl.push_back(mk(8'hFF, 4'h8, 8'h00, 8'h00, 8'h07, 0));
        run_table(8, 0);

        // IN A / MOV B,A / OUT B, then HALT at 6
        fill_nop(4);
        mem4[0] = 8'h20; mem4[1] = 8'h40; mem4[2] = 8'h90; mem4[6] = 8'hC0;
        wait4 = 0; wrand4 = 0; vmode4 = 1;
        gpi4 = 4'h5;
        do_reset(4);
        repeat (3) wait_done(4);
        chk("in/out gpo", gpo4, 4'h5);
        chk("in/out ip", ip4, 4'h3);
        repeat (4) wait_done(4);
        chk("halt flag", halted4, 1);
        chk("halt req", bus4.req, 0);
        chk("halt ip", ip4, 4'h6);
        chk("halt gpo", gpo4, 4'h5);
        gpi4 = 4'hA;
        vmode4 = 2;
        repeat (100) begin
            @(negedge clk);
            chk("halt frozen", {halted4, bus4.req, stb4, ip4, gpo4}, {1'b1, 1'b0, 1'b0, 4'h6, 4'h5});
        end

        // Async reset during EXEC of an ADD
        fill_nop(4);
        mem4[0] = 8'hB7; mem4[1] = 8'h33; mem4[2] = 8'h04;
        vmode4 = 1;
        do_reset(4);
        repeat (2) wait_done(4);
        chk("pre-reset gpo", gpo4, 4'h7);
        chk("pre-reset ip", ip4, 4'h2);
        n = 0;
        do begin @(negedge clk); n++; end while (acc4 !== 1'b1 && n < 20);
        chk("reached exec", acc4, 1);
        #2 rst4_n = 1'b0;
        #1;
        chk("exec reset ip", ip4, 0);
        chk("exec reset gpo", gpo4, 0);
        chk("exec reset req", bus4.req, 0);
        mem4[0] = 8'h40; mem4[1] = 8'h90;
        repeat (2) @(negedge clk);
        rst4_n = 1'b1;
        sc = scnt4;
        repeat (2) wait_done(4);
        chk("add abandoned gpo", gpo4, 0);
        chk("add abandoned ip", ip4, 4'h2);
        chk("add abandoned stb", scnt4 - sc, 1);

        // Async reset in a fetch wait state
        fill_nop(4);
        mem4[0] = 8'hB6; mem4[1] = 8'h03;
        wait4 = 3;
        do_reset(4);
        wait_done(4);
        chk("wait pre gpo", gpo4, 4'h6);
        chk("wait pre ip", ip4, 4'h1);
        repeat (2) @(negedge clk);
        chk("in wait state", bus4.req, 1);
        #2 rst4_n = 1'b0;
        #1;
        chk("wait reset ip", ip4, 0);
        chk("wait reset gpo", gpo4, 0);
        chk("wait reset req", bus4.req, 0);
        mem4[0] = 8'h40; mem4[1] = 8'h90;
        repeat (2) @(negedge clk);
        rst4_n = 1'b1;
        @(posedge clk);
        #1;
        chk("refetch req", bus4.req, 1);
        chk("refetch addr", bus4.addr, 0);
        repeat (2) wait_done(4);
        chk("wait abandoned gpo", gpo4, 0);

        // Random programs against the model, random wait states
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                mem4[i] = 8'($urandom);
                if (mem4[i][7:4] == 4'hC) mem4[i][7:4] = 4'h8;
            end
            gpi4 = 4'($urandom);
            wrand4 = 1; vmode4 = 1;
            m_a = 0; m_b = 0; m_c = 0; m_ip = 0; m_gpo = 0;
            do_reset(4);
            for (int k = 0; k < 40; k++) begin
                sc = scnt4;
                wait_done(4);
                model_step(stbm);
                chk($sformatf("rand%0d.%0d ip", r, k), ip4, m_ip);
                chk($sformatf("rand%0d.%0d gpo", r, k), gpo4, m_gpo);
                chk($sformatf("rand%0d.%0d stb", r, k), scnt4 - sc, stbm);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
